// File: rtl/fpu_issue.sv
// Requester-side sequencer for the FPU: it accepts one op, holds it on the FPU inputs for that op's latency, then returns the result.
// Optional performance counters are enabled by defining FPU_ISSUE_PERF_EN.
`timescale 1ns/1ps
`default_nettype none

module fpu_issue #(
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 1,
  parameter int LAT_DIV  = 4,
  parameter int LAT_SQRT = 4,
  parameter int LAT_MISC = 1,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_src0,
  input  logic [31:0]      req_src1,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      fpu_src0,
  output logic [31:0]      fpu_src1,
  output logic [3:0]       fpu_op,
  input  logic [31:0]      fpu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
`ifdef FPU_ISSUE_PERF_EN
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_stall,
`endif
  output logic             busy
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_LAT = max2(max2(max2(LAT_ADD, LAT_MUL), max2(LAT_DIV, LAT_SQRT)), LAT_MISC);
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter is loaded with latency-1, so a count of zero marks the capture edge.
  function automatic logic [CNT_W-1:0] lat_m1(input logic [3:0] op);
    int lat;
    case (op)
      4'd0, 4'd1:                 lat = LAT_ADD;
      4'd2:                       lat = LAT_MUL;
      4'd3:                       lat = LAT_DIV;
      4'd4:                       lat = LAT_SQRT;
      4'd5, 4'd6, 4'd7, 4'd8,
      4'd9, 4'd10, 4'd11, 4'd12:  lat = LAT_MISC;
      default:                    lat = 1;
    endcase
    return CNT_W'(lat - 1);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'd13);
  endfunction

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [TAG_W-1:0]   tag_r;
  logic               ill_r;
  logic               accept_s;

  assign req_ready = (state_r == IDLE) | ((state_r == DONE) & rsp_ready);
  assign accept_s  = req_valid & req_ready;
  assign rsp_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        if (cnt_r == '0) begin
          state_s = DONE;
        end else begin
          state_s = EXEC;
        end
      end
      DONE: begin
        if (accept_s) begin
          state_s = EXEC;
        end else if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand hold, latency count and result capture; FPU inputs keep the last op while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpu_src0   <= 32'd0;
      fpu_src1   <= 32'd0;
      fpu_op     <= 4'd0;
      tag_r      <= '0;
      ill_r      <= 1'b0;
      cnt_r      <= '0;
      rsp_result <= 32'd0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
    end else if (accept_s) begin
      fpu_src0 <= req_src0;
      fpu_src1 <= req_src1;
      fpu_op   <= is_illegal(req_op) ? 4'hF : req_op;
      tag_r    <= req_tag;
      ill_r    <= is_illegal(req_op);
      cnt_r    <= lat_m1(req_op);
    end else if (state_r == EXEC) begin
      if (cnt_r == '0) begin
        rsp_result <= ill_r ? 32'd0 : fpu_result;
        rsp_tag    <= tag_r;
        rsp_err    <= ill_r;
      end else begin
        cnt_r <= cnt_r - CNT_W'(1);
      end
    end
  end

`ifdef FPU_ISSUE_PERF_EN
  // Retired-op and writeback-stall counters, free-running with natural wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops   <= 32'd0;
      perf_stall <= 32'd0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        perf_ops <= perf_ops + 32'd1;
      end
      if (rsp_valid && !rsp_ready) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire
